// File: rtl/output_vc_status_if.sv
// Status bus between the crossbar/allocator side and the per-OVC status tracker.
// master drives the event pulses and observes the status vectors; slave is the tracker.
interface output_vc_status_if #(
  parameter int P = 5,
  parameter int V = 4,
  parameter int B = 4
);
  localparam int PV = P * V;
  localparam int BW = $clog2(B + 1);

  logic [PV-1:0]    ovc_allocated_all;
  logic [PV-1:0]    ovc_released_all;
  logic [PV-1:0]    flit_sent_all;
  logic [PV-1:0]    credit_in_all;
  logic [PV-1:0]    ovc_avalable_all;
  logic [PV-1:0]    ovc_not_full_all;
  logic [PV-1:0]    ovc_nearly_full_all;
  logic [PV*BW-1:0] credit_count_all;
  logic [P-1:0]     status_error_all;

  modport master (
    output ovc_allocated_all, ovc_released_all, flit_sent_all, credit_in_all,
    input  ovc_avalable_all, ovc_not_full_all, ovc_nearly_full_all,
           credit_count_all, status_error_all
  );

  modport slave (
    input  ovc_allocated_all, ovc_released_all, flit_sent_all, credit_in_all,
    output ovc_avalable_all, ovc_not_full_all, ovc_nearly_full_all,
           credit_count_all, status_error_all
  );
endinterface

// File: rtl/output_vc_status.sv
// Per-OVC allocation flag and saturating credit counter with sticky per-port error flags.
// Events sampled on an edge appear on the outputs the following cycle; inputs are pulses, no backpressure.
module output_vc_status #(
  parameter int V = 4,
  parameter int P = 5,
  parameter int B = 4
) (
  input logic               clk,
  input logic               reset,
  output_vc_status_if.slave bus
);
  localparam int PV = P * V;
  localparam int BW = $clog2(B + 1);
  localparam logic [BW-1:0] CNT_MAX = BW'(B);

  logic [PV-1:0] alloc_q, alloc_d;
  logic [BW-1:0] cnt_q [PV];
  logic [BW-1:0] cnt_d [PV];
  logic [P-1:0]  err_q, err_d;

  always_comb begin
    alloc_d = alloc_q;
    err_d   = err_q;
    for (int i = 0; i < PV; i++) cnt_d[i] = cnt_q[i];

    for (int p = 0; p < P; p++) begin
      for (int v = 0; v < V; v++) begin
        // Release wins over a same-cycle grant: that is a single-flit packet.
        alloc_d[p*V+v] = (alloc_q[p*V+v] | bus.ovc_allocated_all[p*V+v])
                         & ~bus.ovc_released_all[p*V+v];
        if (bus.ovc_allocated_all[p*V+v] & alloc_q[p*V+v] & ~bus.ovc_released_all[p*V+v])
          err_d[p] = 1'b1;
        if (bus.ovc_released_all[p*V+v] & ~alloc_q[p*V+v] & ~bus.ovc_allocated_all[p*V+v])
          err_d[p] = 1'b1;

        // Counter saturates at 0 and B; an out-of-range step is flagged, never wrapped.
        if (bus.flit_sent_all[p*V+v] & ~bus.credit_in_all[p*V+v]) begin
          if (cnt_q[p*V+v] == '0) err_d[p] = 1'b1;
          else                    cnt_d[p*V+v] = cnt_q[p*V+v] - BW'(1);
        end else if (bus.credit_in_all[p*V+v] & ~bus.flit_sent_all[p*V+v]) begin
          if (cnt_q[p*V+v] == CNT_MAX) err_d[p] = 1'b1;
          else                         cnt_d[p*V+v] = cnt_q[p*V+v] + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < PV; i++) cnt_q[i] <= CNT_MAX;
    end else begin
      alloc_q <= alloc_d;
      err_q   <= err_d;
      for (int i = 0; i < PV; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.ovc_avalable_all = ~alloc_q;
  assign bus.status_error_all = err_q;

  for (genvar g = 0; g < PV; g++) begin : g_ovc
    assign bus.ovc_not_full_all[g]         = (cnt_q[g] != '0);
    assign bus.ovc_nearly_full_all[g]      = (cnt_q[g] == BW'(1));
    assign bus.credit_count_all[g*BW +: BW] = cnt_q[g];
  end
endmodule

// File: tb/tb_output_vc_status.sv
// Directed vector table plus hand-written multi-cycle sequences for output_vc_status (P=5, V=4, B=4).
module tb_output_vc_status;
  localparam int P  = 5;
  localparam int V  = 4;
  localparam int B  = 4;
  localparam int PV = P * V;
  localparam int BW = $clog2(B + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  output_vc_status_if #(.P(P), .V(V), .B(B)) bus ();

  output_vc_status #(.V(V), .P(P), .B(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [PV-1:0] a, r, s, c;
    int            idx;
    int            ecnt;
    logic          enf, enear;
    logic [PV-1:0] eav;
    logic [P-1:0]  eerr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [PV-1:0] oh(input int i);
    logic [PV-1:0] one;
    one = PV'(1);
    return one << i;
  endfunction

  task automatic add(input logic [PV-1:0] a, r, s, c, input int idx, input int ecnt,
                     input logic enf, enear, input logic [PV-1:0] eav, input logic [P-1:0] eerr);
    vec_t t;
    t.a = a; t.r = r; t.s = s; t.c = c; t.idx = idx; t.ecnt = ecnt;
    t.enf = enf; t.enear = enear; t.eav = eav; t.eerr = eerr;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [PV-1:0] a, r, s, c);
    bus.ovc_allocated_all = a;
    bus.ovc_released_all  = r;
    bus.flit_sent_all     = s;
    bus.credit_in_all     = c;
  endtask

  task automatic chk_reset_state(input string tag);
    logic [PV*BW-1:0] full;
    for (int i = 0; i < PV; i++) full[i*BW +: BW] = BW'(B);
    chk({tag, "_avail"},  bus.ovc_avalable_all,    {PV{1'b1}});
    chk({tag, "_nf"},     bus.ovc_not_full_all,    {PV{1'b1}});
    chk({tag, "_nearly"}, bus.ovc_nearly_full_all, '0);
    chk({tag, "_cnt"},    bus.credit_count_all,    full);
    chk({tag, "_err"},    bus.status_error_all,    '0);
  endtask

  localparam logic [PV-1:0] Z   = '0;
  localparam logic [PV-1:0] ALL = {PV{1'b1}};

  initial begin
    // idle | alloc | rel | sent | credit | chk idx | cnt | nf | nearly | avail | err
    add(Z, Z, oh(6), Z,  6, 3, 1, 0, ALL, 5'b00000);
    add(Z, Z, oh(6), Z,  6, 2, 1, 0, ALL, 5'b00000);
    add(Z, Z, oh(6), Z,  6, 1, 1, 1, ALL, 5'b00000);
    add(Z, Z, oh(6), Z,  6, 0, 0, 0, ALL, 5'b00000);
    add(Z, Z, oh(6), Z,  6, 0, 0, 0, ALL, 5'b00010);  // underflow
    add(Z, Z, Z, oh(6),  6, 1, 1, 1, ALL, 5'b00010);
    add(Z, Z, Z, oh(6),  6, 2, 1, 0, ALL, 5'b00010);
    add(Z, Z, Z, oh(6),  6, 3, 1, 0, ALL, 5'b00010);
    add(Z, Z, Z, oh(6),  6, 4, 1, 0, ALL, 5'b00010);
    add(Z, Z, oh(0), Z,  0, 3, 1, 0, ALL, 5'b00010);
    add(Z, Z, oh(0), Z,  0, 2, 1, 0, ALL, 5'b00010);
    add(Z, Z, oh(0), oh(0), 0, 2, 1, 0, ALL, 5'b00010);
    add(oh(3), Z, Z, Z,  3, 4, 1, 0, ALL & ~oh(3), 5'b00010);
    add(Z, Z, Z, Z,      3, 4, 1, 0, ALL & ~oh(3), 5'b00010);
    add(Z, Z, Z, Z,      3, 4, 1, 0, ALL & ~oh(3), 5'b00010);
    add(Z, Z, Z, Z,      3, 4, 1, 0, ALL & ~oh(3), 5'b00010);
    add(Z, Z, Z, Z,      3, 4, 1, 0, ALL & ~oh(3), 5'b00010);
    add(Z, oh(3), Z, Z,  3, 4, 1, 0, ALL, 5'b00010);
    add(oh(4), oh(4), Z, Z, 4, 4, 1, 0, ALL, 5'b00010);
    add(oh(9), Z, Z, Z,  9, 4, 1, 0, ALL & ~oh(9), 5'b00010);
    add(oh(9), Z, Z, Z,  9, 4, 1, 0, ALL & ~oh(9), 5'b00110); // double allocation
    add(Z, Z, Z, Z,      9, 4, 1, 0, ALL & ~oh(9), 5'b00110);
    add(Z, Z, Z, oh(19), 19, 4, 1, 0, ALL & ~oh(9), 5'b10110); // overflow
    add(Z, oh(12), Z, Z, 12, 4, 1, 0, ALL & ~oh(9), 5'b11110); // release of free OVC

    drive(Z, Z, Z, Z);
    repeat (2) @(posedge clk);
    #1 chk_reset_state("reset_init");
    @(negedge clk) reset = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].a, vecs[k].r, vecs[k].s, vecs[k].c);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_avail", k),  bus.ovc_avalable_all, vecs[k].eav);
      chk($sformatf("v%0d_err", k),    bus.status_error_all, vecs[k].eerr);
      chk($sformatf("v%0d_cnt", k),    bus.credit_count_all[vecs[k].idx*BW +: BW], vecs[k].ecnt);
      chk($sformatf("v%0d_nf", k),     bus.ovc_not_full_all[vecs[k].idx], vecs[k].enf);
      chk($sformatf("v%0d_nearly", k), bus.ovc_nearly_full_all[vecs[k].idx], vecs[k].enear);
    end

    // A send held high for three cycles counts as three events.
    @(negedge clk) drive(Z, Z, oh(15), Z);
    repeat (3) @(posedge clk);
    #1;
    chk("held_cnt15",    bus.credit_count_all[15*BW +: BW], 1);
    chk("held_nearly15", bus.ovc_nearly_full_all[15], 1'b1);
    chk("held_err",      bus.status_error_all, 5'b11110);
    @(negedge clk) drive(Z, Z, Z, Z);
    @(posedge clk);
    #1 chk("held_stop_cnt15", bus.credit_count_all[15*BW +: BW], 1);

    // Asynchronous reset mid-cycle must clear everything before the next edge.
    #2 reset = 1'b1;
    #1 chk_reset_state("reset_async");
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 chk_reset_state("reset_release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
